// File: rtl/ram_burst_reader_pkg.sv
// Shared types and default widths for the RAM burst reader slice.
// The optional checksum feature is enabled by defining BURST_CKSUM_EN.
package ram_prd_pkg;

  localparam int unsigned RAM_ADDR_W = 9;
  localparam int unsigned RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Control, RAM read port and output stream of the burst reader.
// Defining BURST_CKSUM_EN adds the Cksum signal.
interface ram_burst_reader_if
  import ram_prd_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
);

  logic              Start;
  logic [ADDR_W-1:0] Base_Addr;
  logic [ADDR_W:0]   Length;
  logic              Busy;
  logic              Done;
  logic [ADDR_W-1:0] RA;
  logic              RClk_En;
  logic [DATA_W-1:0] RD;
  logic [DATA_W-1:0] Out_Data;
  logic              Out_Valid;
  logic              Out_Ready;
`ifdef BURST_CKSUM_EN
  logic [DATA_W-1:0] Cksum;

  modport master (
    input  Start, Base_Addr, Length, RD, Out_Ready,
    output Busy, Done, RA, RClk_En, Out_Data, Out_Valid, Cksum
  );
  modport slave (
    output Start, Base_Addr, Length, RD, Out_Ready,
    input  Busy, Done, RA, RClk_En, Out_Data, Out_Valid, Cksum
  );
`else
  modport master (
    input  Start, Base_Addr, Length, RD, Out_Ready,
    output Busy, Done, RA, RClk_En, Out_Data, Out_Valid
  );
  modport slave (
    output Start, Base_Addr, Length, RD, Out_Ready,
    input  Busy, Done, RA, RClk_En, Out_Data, Out_Valid
  );
`endif

endinterface

// File: rtl/ram_rd_skid_fifo.sv
// Return-data FIFO: output register plus DEPTH-1 entry ring buffer.
// count includes the word currently held in the output register.
module ram_rd_skid_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned BUF = DEPTH - 1;
  localparam int unsigned PW  = (BUF > 1) ? $clog2(BUF) : 1;

  logic [DATA_W-1:0] mem [BUF];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  bcnt;
  logic              load_out, buf_pop, buf_push, bypass;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF - 1)) ? '0 : p + PW'(1);
  endfunction

  // A write into an empty buffer while the output slot is free goes straight to dout.
  always_comb begin
    load_out = !dout_valid || rd_en;
    buf_pop  = load_out && (bcnt != '0);
    bypass   = load_out && (bcnt == '0) && wr_en;
    buf_push = wr_en && !bypass;
  end

  always_ff @(posedge clk) begin
    if (buf_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      bcnt       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (buf_push) wr_ptr <= ptr_inc(wr_ptr);
      if (buf_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (load_out) begin
        if (buf_pop) begin
          dout       <= mem[rd_ptr];
          dout_valid <= 1'b1;
        end else if (bypass) begin
          dout       <= wr_data;
          dout_valid <= 1'b1;
        end else begin
          dout_valid <= 1'b0;
        end
      end
      bcnt <= bcnt + CNT_W'(buf_push) - CNT_W'(buf_pop);
    end
  end

  assign count = bcnt + CNT_W'(dout_valid);

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for a registered-read RAM, streaming words in order.
// Defining BURST_CKSUM_EN adds a running checksum of delivered words.
module ram_burst_reader
  import ram_prd_pkg::*;
#(
  parameter int unsigned ADDR_W     = RAM_ADDR_W,
  parameter int unsigned DATA_W     = RAM_DATA_W,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  ram_burst_reader_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W + 1)'(1);

  if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_check
    $error("ram_burst_reader: FIFO_DEPTH must be >= RD_LAT+1");
  end

  rd_state_t         state, state_next;
  logic [ADDR_W-1:0] ra_q;
  logic [ADDR_W:0]   rem, out_rem, len_clamped;
  logic [RD_LAT-1:0] tag;
  logic [CNT_W-1:0]  fifo_count;
  logic [CW-1:0]     inflight;
  logic              start_go, credit_ok, issue_fire, hs;

  assign bus.RA      = ra_q;
  assign bus.Busy    = (state == ISSUE) || (state == DRAIN);
  assign bus.RClk_En = (state == ISSUE) || (state == DRAIN);
  assign bus.Done    = (state == DONE);

  assign len_clamped = (bus.Length > MAX_LEN) ? MAX_LEN : bus.Length;
  assign start_go    = (state == IDLE) && bus.Start;
  assign hs          = bus.Out_Valid && bus.Out_Ready;

  // Words already requested but not yet in the FIFO still reserve a slot.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight += CW'(tag[i]);
  end

  assign credit_ok  = (inflight + CW'(fifo_count)) < CW'(FIFO_DEPTH);
  assign issue_fire = (state == ISSUE) && credit_ok;

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.Start) state_next = (bus.Length == '0) ? DONE : ISSUE;
      ISSUE: if (issue_fire && rem == ONE_LEN) state_next = DRAIN;
      DRAIN: if (hs && out_rem == ONE_LEN) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RA stays on the final address once the last word has been issued.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ra_q    <= '0;
      rem     <= '0;
      out_rem <= '0;
      tag     <= '0;
    end else begin
      tag[0] <= issue_fire;
      for (int unsigned i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
      if (start_go) begin
        ra_q    <= bus.Base_Addr;
        rem     <= len_clamped;
        out_rem <= len_clamped;
      end else begin
        if (issue_fire) begin
          rem <= rem - ONE_LEN;
          if (rem != ONE_LEN) ra_q <= ra_q + ADDR_W'(1);
        end
        if (hs) out_rem <= out_rem - ONE_LEN;
      end
    end
  end

  ram_rd_skid_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .wr_en      (tag[RD_LAT-1]),
    .wr_data    (bus.RD),
    .rd_en      (hs),
    .dout       (bus.Out_Data),
    .dout_valid (bus.Out_Valid),
    .count      (fifo_count)
  );

`ifdef BURST_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n)        cksum_q <= '0;
    else if (start_go) cksum_q <= '0;
    else if (hs)       cksum_q <= cksum_q + bus.Out_Data;
  end

  assign bus.Cksum = cksum_q;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader with a registered-read RAM model.
// Checksum checks are included when BURST_CKSUM_EN is defined.
module tb_ram_burst_reader;
  import ram_prd_pkg::*;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          DEPTH_W    = 1 << ADDR_W;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  ram_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_burst_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  // RAM model: address register then output register, both gated by RClk_En.
  logic [DATA_W-1:0] mem [DEPTH_W];
  logic [ADDR_W-1:0] ram_addr_q;
  always @(posedge Clk) begin
    if (bus.RClk_En) begin
      ram_addr_q <= bus.RA;
      bus.RD     <= mem[ram_addr_q];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_sum;
  int                hs_cnt = 0;
  int                last_hs_cyc = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 32'({bus.Out_Valid, bus.Out_Data}), 32'({1'b1, prev_data}));
      if (bus.Out_Valid && bus.Out_Ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) check("sb_extra", 32'(bus.Out_Data), 32'h10000);
        else                   check("sb_data", 32'(bus.Out_Data), 32'(exp_q.pop_front()));
      end
      prev_stall = bus.Out_Valid && !bus.Out_Ready;
      prev_data  = bus.Out_Data;
    end
  end

  task automatic run_burst(input logic [ADDR_W-1:0] base, input int len,
                           input int st_lo, input int st_hi, input bit chk_ra);
    int n, k, hs0, done_cyc;
    bit seen;
    n = (len > DEPTH_W) ? DEPTH_W : len;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      logic [DATA_W-1:0] w;
      w = mem[(int'(base) + i) % DEPTH_W];
      exp_q.push_back(w);
      exp_sum += w;
    end
    hs0           = hs_cnt;
    done_cyc      = 0;
    bus.Base_Addr = base;
    bus.Length    = (ADDR_W + 1)'(len);
    bus.Start     = 1'b1;
    bus.Out_Ready = 1'b1;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 4 * n + 40) begin
      @(posedge Clk); #1;
      k++;
      bus.Start     = 1'b0;
      bus.Out_Ready = (k >= st_lo && k <= st_hi) ? 1'b0 : 1'b1;
      if (chk_ra && k <= n) check("ra_seq", 32'(bus.RA), 32'((int'(base) + k - 1) % DEPTH_W));
      if (chk_ra && k == RD_LAT + 1) check("valid_early", 32'(bus.Out_Valid), 0);
      if (chk_ra && k == RD_LAT + 2) check("valid_first", 32'(bus.Out_Valid), 1);
      if (k == 1) check("busy_start", 32'(bus.Busy), 1);
      if (bus.Done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    check("done_seen", 32'(seen), 1);
    if (seen) begin
      check("done_gap", done_cyc - last_hs_cyc, 1);
      check("done_busy", 32'(bus.Busy), 0);
      if (chk_ra) check("done_cycle", k, n + RD_LAT + 2);
`ifdef BURST_CKSUM_EN
      check("cksum", 32'(bus.Cksum), 32'(exp_sum));
`endif
    end
    check("word_count", hs_cnt - hs0, n);
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge Clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH_W; i++) mem[i] = 16'((i * 40503) ^ 32'h5A5A);
    bus.Start     = 1'b0;
    bus.Base_Addr = '0;
    bus.Length    = '0;
    bus.Out_Ready = 1'b1;
    bus.RD        = '0;
    Rst_n         = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_state", 32'({bus.Busy, bus.Done, bus.RA, bus.RClk_En, bus.Out_Valid, bus.Out_Data}), 0);
`ifdef BURST_CKSUM_EN
    check("rst_cksum", 32'(bus.Cksum), 0);
`endif
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    run_burst(9'h010, 4, -1, -1, 1'b1);
    run_burst(9'h1FE, 4, -1, -1, 1'b1);
    run_burst(9'h020, 16, 5, 14, 1'b0);

    // Empty burst: Done on the next cycle, nothing else moves.
    bus.Base_Addr = 9'h055;
    bus.Length    = '0;
    bus.Start     = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      check("len0_done", 32'(bus.Done), (k == 1) ? 1 : 0);
      check("len0_quiet", 32'({bus.Busy, bus.RClk_En, bus.Out_Valid}), 0);
    end

    run_burst(9'h0A5, 1023, -1, -1, 1'b1);

    // Reset in cycle 6 of a 32-word burst.
    bus.Base_Addr = 9'h040;
    bus.Length    = 10'd32;
    bus.Start     = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back(mem[9'h040 + i]);
    for (int k = 1; k <= 6; k++) begin
      @(posedge Clk); #1;
      bus.Start = 1'b0;
    end
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    check("midrst_state", 32'({bus.Busy, bus.Done, bus.RA, bus.RClk_En, bus.Out_Valid, bus.Out_Data}), 0);
    exp_q.delete();
    Rst_n = 1'b1;
    run_burst(9'h123, 5, -1, -1, 1'b1);

`ifdef BURST_CKSUM_EN
    mem[9'h100] = 16'hFFFF;
    mem[9'h101] = 16'h0002;
    mem[9'h102] = 16'h0010;
    run_burst(9'h100, 3, -1, -1, 1'b1);
    check("cksum_vec_hold", 32'(bus.Cksum), 32'h0011);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
